// File: rtl/otter_reg_file_sb_if.sv
// Bus bundle for the OTTER register file: writeback, operand reads and issue handshake.
// The core side uses master; the register file uses slave.
interface otter_reg_file_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            WR_EN;
  logic [AW-1:0]   WR_ADDR;
  logic [XLEN-1:0] WR_DATA;
  logic [AW-1:0]   ADDR1;
  logic [AW-1:0]   ADDR2;
  logic [XLEN-1:0] RS1;
  logic [XLEN-1:0] RS2;
  logic            RS1_BUSY;
  logic            RS2_BUSY;
  logic            ISSUE_EN;
  logic [AW-1:0]   ISSUE_ADDR;
  logic            ISSUE_RDY;
  logic            PEND_ANY;
  logic            ERR_UNDERFLOW;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, ADDR1, ADDR2, ISSUE_EN, ISSUE_ADDR,
    input  RS1, RS2, RS1_BUSY, RS2_BUSY, ISSUE_RDY, PEND_ANY, ERR_UNDERFLOW
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, ADDR1, ADDR2, ISSUE_EN, ISSUE_ADDR,
    output RS1, RS2, RS1_BUSY, RS2_BUSY, ISSUE_RDY, PEND_ANY, ERR_UNDERFLOW
  );
endinterface

// File: rtl/otter_reg_file_sb.sv
// OTTER integer register file with per-register pending-write counters
// (scoreboard) and optional same-cycle writeback forwarding to the read ports.
module otter_reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1,
  parameter int PEND_W = 2
) (
  input logic              CLK,
  input logic              RST,
  otter_reg_file_sb_if.slave bus
);

  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(0);

  logic [XLEN-1:0]   regs_r    [NREGS];
  logic [PEND_W-1:0] cnt_r     [NREGS];
  logic [PEND_W-1:0] cnt_nxt_s [NREGS];
  logic              err_r;
  logic              wr_hit_s;
  logic              iss_ok_s;
  logic              issue_rdy_s;
  logic              issue_acc_s;
  logic              same_addr_s;
  logic              underflow_s;
  logic              pend_any_s;
  logic              ok1_s;
  logic              ok2_s;
  logic              byp1_s;
  logic              byp2_s;

  // Entry 0 and addresses beyond NREGS have no storage and no counter.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != AW'(0)) && (32'(a) < NREGS);
  endfunction

  assign wr_hit_s    = bus.WR_EN && addr_ok(bus.WR_ADDR);
  assign iss_ok_s    = addr_ok(bus.ISSUE_ADDR);
  assign same_addr_s = issue_acc_s && (bus.ISSUE_ADDR == bus.WR_ADDR);

  // Issue acceptance: a full counter only frees up when it is retiring this cycle.
  always_comb begin
    issue_rdy_s = 1'b1;
    if (iss_ok_s) begin
      issue_rdy_s = (cnt_r[bus.ISSUE_ADDR] != PEND_MAX) ||
                    (bus.WR_EN && (bus.WR_ADDR == bus.ISSUE_ADDR));
    end else begin
      issue_rdy_s = 1'b1;
    end
    issue_acc_s = bus.ISSUE_EN && issue_rdy_s && iss_ok_s;
  end

  // Retire against an empty counter is flagged unless an issue refills it in the same cycle.
  always_comb begin
    underflow_s = 1'b0;
    if (wr_hit_s) begin
      underflow_s = (cnt_r[bus.WR_ADDR] == PEND_ZERO) && !same_addr_s;
    end else begin
      underflow_s = 1'b0;
    end
  end

  // Next pending count per register; simultaneous issue and retire cancel out.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (i == 0) begin
        cnt_nxt_s[i] = PEND_ZERO;
      end else if (issue_acc_s && (bus.ISSUE_ADDR == AW'(i)) &&
                   !(wr_hit_s && (bus.WR_ADDR == AW'(i)))) begin
        cnt_nxt_s[i] = cnt_r[i] + PEND_ONE;
      end else if (wr_hit_s && (bus.WR_ADDR == AW'(i)) &&
                   !(issue_acc_s && (bus.ISSUE_ADDR == AW'(i))) &&
                   (cnt_r[i] != PEND_ZERO)) begin
        cnt_nxt_s[i] = cnt_r[i] - PEND_ONE;
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Any outstanding write anywhere in the file.
  always_comb begin
    pend_any_s = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      pend_any_s = pend_any_s | (cnt_r[i] != PEND_ZERO);
    end
  end

  // State update: register data, pending counters and the sticky underflow flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= XLEN'(0);
        cnt_r[i]  <= PEND_ZERO;
      end
      err_r <= 1'b0;
    end else begin
      if (wr_hit_s) begin
        regs_r[bus.WR_ADDR] <= bus.WR_DATA;
      end
      for (int i = 0; i < NREGS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      if (underflow_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // A forwarded final write clears busy: the consumer already has the value.
  assign ok1_s  = addr_ok(bus.ADDR1);
  assign ok2_s  = addr_ok(bus.ADDR2);
  assign byp1_s = (BYPASS != 0) && wr_hit_s && (bus.WR_ADDR == bus.ADDR1);
  assign byp2_s = (BYPASS != 0) && wr_hit_s && (bus.WR_ADDR == bus.ADDR2);

  assign bus.RS1 = !ok1_s ? XLEN'(0) : (byp1_s ? bus.WR_DATA : regs_r[bus.ADDR1]);
  assign bus.RS2 = !ok2_s ? XLEN'(0) : (byp2_s ? bus.WR_DATA : regs_r[bus.ADDR2]);
  assign bus.RS1_BUSY = ok1_s && (byp1_s ? (cnt_r[bus.ADDR1] > PEND_ONE)
                                         : (cnt_r[bus.ADDR1] != PEND_ZERO));
  assign bus.RS2_BUSY = ok2_s && (byp2_s ? (cnt_r[bus.ADDR2] > PEND_ONE)
                                         : (cnt_r[bus.ADDR2] != PEND_ZERO));

  assign bus.ISSUE_RDY     = issue_rdy_s;
  assign bus.PEND_ANY      = pend_any_s;
  assign bus.ERR_UNDERFLOW = err_r;

endmodule

// File: tb/tb_otter_reg_file_sb.sv
// Directed bench for otter_reg_file_sb: one bypassing and one non-bypassing
// instance receive identical stimulus and are checked against hand-computed values.
module tb_otter_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  addr1;
  logic [4:0]  addr2;
  logic        issue_en;
  logic [4:0]  issue_addr;
  int          checks = 0;
  int          errors = 0;

  otter_reg_file_sb_if #(.XLEN(32), .AW(5)) bus_b ();
  otter_reg_file_sb_if #(.XLEN(32), .AW(5)) bus_n ();

  assign bus_b.WR_EN = wr_en;       assign bus_n.WR_EN = wr_en;
  assign bus_b.WR_ADDR = wr_addr;   assign bus_n.WR_ADDR = wr_addr;
  assign bus_b.WR_DATA = wr_data;   assign bus_n.WR_DATA = wr_data;
  assign bus_b.ADDR1 = addr1;       assign bus_n.ADDR1 = addr1;
  assign bus_b.ADDR2 = addr2;       assign bus_n.ADDR2 = addr2;
  assign bus_b.ISSUE_EN = issue_en; assign bus_n.ISSUE_EN = issue_en;
  assign bus_b.ISSUE_ADDR = issue_addr; assign bus_n.ISSUE_ADDR = issue_addr;

  otter_reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1), .PEND_W(2)) dut_b (
    .CLK(clk), .RST(rst), .bus(bus_b)
  );
  otter_reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(0), .PEND_W(2)) dut_n (
    .CLK(clk), .RST(rst), .bus(bus_n)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    issue_en = 1'b0; issue_addr = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cyc();
    wr_en = 1'b0; addr1 = 5'd5;
    @(negedge clk);
    checks++; if (bus_b.RS1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_pre_x5: got %h want %h", bus_b.RS1, 32'hDEADBEEF); end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; issue_addr = 5'd5;
    @(negedge clk);
    checks++; if (bus_b.RS1 !== 32'h0) begin errors++; $display("FAIL rst_rs1_b: got %h want %h", bus_b.RS1, 32'h0); end
    checks++; if (bus_n.RS1 !== 32'h0) begin errors++; $display("FAIL rst_rs1_n: got %h want %h", bus_n.RS1, 32'h0); end
    checks++; if (bus_b.RS1_BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus_b.RS1_BUSY); end
    checks++; if (bus_b.ISSUE_RDY !== 1'b1) begin errors++; $display("FAIL rst_rdy: got %b want 1", bus_b.ISSUE_RDY); end
    checks++; if (bus_b.PEND_ANY !== 1'b0) begin errors++; $display("FAIL rst_pend: got %b want 0", bus_b.PEND_ANY); end
    checks++; if (bus_b.ERR_UNDERFLOW !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus_b.ERR_UNDERFLOW); end
    cyc();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; addr1 = 5'd0;
    @(negedge clk);
    checks++; if (bus_b.RS1 !== 32'h0) begin errors++; $display("FAIL x0_fwd: got %h want %h", bus_b.RS1, 32'h0); end
    cyc();
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (bus_b.RS1 !== 32'h0) begin errors++; $display("FAIL x0_read: got %h want %h", bus_b.RS1, 32'h0); end
    checks++; if (bus_b.RS1_BUSY !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b want 0", bus_b.RS1_BUSY); end
    cyc();
  endtask

  task automatic test_scoreboard();
    issue_en = 1'b1; issue_addr = 5'd7;
    @(negedge clk);
    checks++; if (bus_b.ISSUE_RDY !== 1'b1) begin errors++; $display("FAIL sb_rdy: got %b want 1", bus_b.ISSUE_RDY); end
    cyc();
    issue_en = 1'b0; addr1 = 5'd7;
    @(negedge clk);
    checks++; if (bus_b.RS1_BUSY !== 1'b1) begin errors++; $display("FAIL sb_busy_b: got %b want 1", bus_b.RS1_BUSY); end
    checks++; if (bus_n.RS1_BUSY !== 1'b1) begin errors++; $display("FAIL sb_busy_n: got %b want 1", bus_n.RS1_BUSY); end
    checks++; if (bus_b.PEND_ANY !== 1'b1) begin errors++; $display("FAIL sb_pend: got %b want 1", bus_b.PEND_ANY); end
    cyc();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    @(negedge clk);
    checks++; if (bus_b.RS1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_rs1: got %h want %h", bus_b.RS1, 32'hA5A5A5A5); end
    checks++; if (bus_b.RS1_BUSY !== 1'b0) begin errors++; $display("FAIL byp_busy: got %b want 0", bus_b.RS1_BUSY); end
    checks++; if (bus_n.RS1 !== 32'h0) begin errors++; $display("FAIL nobyp_rs1: got %h want %h", bus_n.RS1, 32'h0); end
    checks++; if (bus_n.RS1_BUSY !== 1'b1) begin errors++; $display("FAIL nobyp_busy: got %b want 1", bus_n.RS1_BUSY); end
    cyc();
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (bus_b.RS1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_after_b: got %h want %h", bus_b.RS1, 32'hA5A5A5A5); end
    checks++; if (bus_n.RS1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_after_n: got %h want %h", bus_n.RS1, 32'hA5A5A5A5); end
    checks++; if (bus_n.RS1_BUSY !== 1'b0) begin errors++; $display("FAIL sb_after_busy_n: got %b want 0", bus_n.RS1_BUSY); end
    checks++; if (bus_b.PEND_ANY !== 1'b0) begin errors++; $display("FAIL sb_after_pend: got %b want 0", bus_b.PEND_ANY); end
    cyc();
  endtask

  task automatic test_saturation();
    addr2 = 5'd3; issue_en = 1'b1; issue_addr = 5'd3;
    cyc(); cyc(); cyc();
    @(negedge clk);
    checks++; if (bus_b.ISSUE_RDY !== 1'b0) begin errors++; $display("FAIL sat_rdy_b: got %b want 0", bus_b.ISSUE_RDY); end
    checks++; if (bus_n.ISSUE_RDY !== 1'b0) begin errors++; $display("FAIL sat_rdy_n: got %b want 0", bus_n.ISSUE_RDY); end
    checks++; if (bus_b.RS2_BUSY !== 1'b1) begin errors++; $display("FAIL sat_busy: got %b want 1", bus_b.RS2_BUSY); end
    cyc();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    @(negedge clk);
    checks++; if (bus_b.ISSUE_RDY !== 1'b1) begin errors++; $display("FAIL sat_rdy_ret: got %b want 1", bus_b.ISSUE_RDY); end
    checks++; if (bus_b.RS2 !== 32'h33) begin errors++; $display("FAIL sat_rs2_fwd: got %h want %h", bus_b.RS2, 32'h33); end
    checks++; if (bus_b.RS2_BUSY !== 1'b1) begin errors++; $display("FAIL sat_busy_ret: got %b want 1", bus_b.RS2_BUSY); end
    cyc();
    issue_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    checks++; if (bus_b.ISSUE_RDY !== 1'b0) begin errors++; $display("FAIL sat_still3: got %b want 0", bus_b.ISSUE_RDY); end
    checks++; if (bus_n.RS2 !== 32'h33) begin errors++; $display("FAIL sat_rs2: got %h want %h", bus_n.RS2, 32'h33); end
    cyc();
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h40 + 32'(k);
      @(negedge clk);
      checks++;
      if (bus_b.RS2_BUSY !== (k != 2)) begin
        errors++; $display("FAIL sat_retire%0d_busy: got %b want %b", k, bus_b.RS2_BUSY, (k != 2));
      end
      cyc();
    end
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (bus_b.RS2_BUSY !== 1'b0) begin errors++; $display("FAIL sat_end_busy: got %b want 0", bus_b.RS2_BUSY); end
    checks++; if (bus_n.RS2_BUSY !== 1'b0) begin errors++; $display("FAIL sat_end_busy_n: got %b want 0", bus_n.RS2_BUSY); end
    checks++; if (bus_b.PEND_ANY !== 1'b0) begin errors++; $display("FAIL sat_end_pend: got %b want 0", bus_b.PEND_ANY); end
    checks++; if (bus_b.ERR_UNDERFLOW !== 1'b0) begin errors++; $display("FAIL sat_end_err: got %b want 0", bus_b.ERR_UNDERFLOW); end
    checks++; if (bus_b.RS2 !== 32'h42) begin errors++; $display("FAIL sat_end_rs2: got %h want %h", bus_b.RS2, 32'h42); end
    cyc();
  endtask

  task automatic test_underflow();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11; addr1 = 5'd9;
    @(negedge clk);
    checks++; if (bus_b.ERR_UNDERFLOW !== 1'b0) begin errors++; $display("FAIL uf_early: got %b want 0", bus_b.ERR_UNDERFLOW); end
    cyc();
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (bus_n.RS1 !== 32'h11) begin errors++; $display("FAIL uf_data: got %h want %h", bus_n.RS1, 32'h11); end
    checks++; if (bus_b.ERR_UNDERFLOW !== 1'b1) begin errors++; $display("FAIL uf_err_b: got %b want 1", bus_b.ERR_UNDERFLOW); end
    checks++; if (bus_n.ERR_UNDERFLOW !== 1'b1) begin errors++; $display("FAIL uf_err_n: got %b want 1", bus_n.ERR_UNDERFLOW); end
    checks++; if (bus_b.RS1_BUSY !== 1'b0) begin errors++; $display("FAIL uf_busy: got %b want 0", bus_b.RS1_BUSY); end
    cyc();
    @(negedge clk);
    checks++; if (bus_b.ERR_UNDERFLOW !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", bus_b.ERR_UNDERFLOW); end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus_b.ERR_UNDERFLOW !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b want 0", bus_b.ERR_UNDERFLOW); end
    checks++; if (bus_b.RS1 !== 32'h0) begin errors++; $display("FAIL uf_rst_data: got %h want %h", bus_b.RS1, 32'h0); end
    cyc();
  endtask

  task automatic test_back_to_back();
    issue_en = 1'b1; issue_addr = 5'd10;
    cyc();
    issue_addr = 5'd11; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hAA;
    addr1 = 5'd10; addr2 = 5'd11;
    @(negedge clk);
    checks++; if (bus_b.RS1 !== 32'hAA) begin errors++; $display("FAIL b2b_fwd: got %h want %h", bus_b.RS1, 32'hAA); end
    checks++; if (bus_b.RS1_BUSY !== 1'b0) begin errors++; $display("FAIL b2b_busy1: got %b want 0", bus_b.RS1_BUSY); end
    checks++; if (bus_b.RS2_BUSY !== 1'b0) begin errors++; $display("FAIL b2b_busy2_pre: got %b want 0", bus_b.RS2_BUSY); end
    cyc();
    issue_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    checks++; if (bus_n.RS1_BUSY !== 1'b0) begin errors++; $display("FAIL b2b_x10_done: got %b want 0", bus_n.RS1_BUSY); end
    checks++; if (bus_n.RS2_BUSY !== 1'b1) begin errors++; $display("FAIL b2b_x11_busy: got %b want 1", bus_n.RS2_BUSY); end
    checks++; if (bus_b.ERR_UNDERFLOW !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", bus_b.ERR_UNDERFLOW); end
    cyc();
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hBB;
    cyc();
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (bus_b.PEND_ANY !== 1'b0) begin errors++; $display("FAIL b2b_pend: got %b want 0", bus_b.PEND_ANY); end
    checks++; if (bus_b.RS2 !== 32'hBB) begin errors++; $display("FAIL b2b_rs2: got %h want %h", bus_b.RS2, 32'hBB); end
    cyc();
  endtask

  task automatic test_reset_mid();
    issue_en = 1'b1; issue_addr = 5'd4;
    cyc();
    issue_addr = 5'd6;
    cyc();
    issue_en = 1'b0;
    @(negedge clk);
    checks++; if (bus_b.PEND_ANY !== 1'b1) begin errors++; $display("FAIL mid_pend_pre: got %b want 1", bus_b.PEND_ANY); end
    cyc();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    issue_en = 1'b1; issue_addr = 5'd6;
    cyc();
    rst = 1'b0; wr_en = 1'b0; issue_en = 1'b0; addr1 = 5'd4; addr2 = 5'd6;
    @(negedge clk);
    checks++; if (bus_b.RS1 !== 32'h0) begin errors++; $display("FAIL mid_x4: got %h want %h", bus_b.RS1, 32'h0); end
    checks++; if (bus_b.RS1_BUSY !== 1'b0) begin errors++; $display("FAIL mid_busy4: got %b want 0", bus_b.RS1_BUSY); end
    checks++; if (bus_b.RS2_BUSY !== 1'b0) begin errors++; $display("FAIL mid_busy6: got %b want 0", bus_b.RS2_BUSY); end
    checks++; if (bus_b.PEND_ANY !== 1'b0) begin errors++; $display("FAIL mid_pend_b: got %b want 0", bus_b.PEND_ANY); end
    checks++; if (bus_n.PEND_ANY !== 1'b0) begin errors++; $display("FAIL mid_pend_n: got %b want 0", bus_n.PEND_ANY); end
    cyc();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    cyc();
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (bus_b.ERR_UNDERFLOW !== 1'b1) begin errors++; $display("FAIL mid_cnt_zero: got %b want 1", bus_b.ERR_UNDERFLOW); end
    checks++; if (bus_b.RS1 !== 32'h55) begin errors++; $display("FAIL mid_x4_new: got %h want %h", bus_b.RS1, 32'h55); end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; addr1 = 5'd0; addr2 = 5'd0;
    idle();
    cyc(); cyc();
    test_reset();
    idle();
    test_scoreboard();
    idle();
    test_saturation();
    idle();
    test_underflow();
    idle();
    test_back_to_back();
    idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otter_reg_file_sb.md
# otter_reg_file_sb

Parametrised OTTER integer register file with a per-register pending-write scoreboard and optional write-through bypass. It serves the pipelined core in two ways. Decode reads operands combinationally and marks the destination as in flight at issue. Writeback commits results and retires the pending marks. The busy outputs drive the hazard/stall unit directly, so the pipeline no longer tracks destinations in separate compare logic.

## Interface
- XLEN, 32: register data width in bits.
- NREGS, 32: number of architectural registers; register 0 is hard-wired zero.
- AW, $clog2(NREGS): address width.
- BYPASS, 1: 1 = same-cycle writeback data is forwarded to read ports; 0 = reads see stored values only.
- PEND_W, 2: width of each per-register pending counter; max in-flight writes per register = 2^PEND_W − 1.

Ports:
- CLK  in  1  rising-edge clock; the block's only clock.
- RST  in  1  reset, synchronous, active-high.
- WR_EN  in  1  writeback commit strobe.
- WR_ADDR  in  AW  writeback destination.
- WR_DATA  in  XLEN  writeback data.
- ADDR1, ADDR2  in  AW  read addresses.
- RS1, RS2  out  XLEN  read data.
- RS1_BUSY, RS2_BUSY  out  1  the addressed register has an uncommitted pending write.
- ISSUE_EN  in  1  decode issues an instruction that writes ISSUE_ADDR.
- ISSUE_ADDR  in  AW  destination of the issuing instruction.
- ISSUE_RDY  out  1  the issue can be accepted this cycle.
- PEND_ANY  out  1  at least one register has a nonzero pending count.
- ERR_UNDERFLOW  out  1  sticky flag: a writeback hit a register with pending count 0.

## Operation
- **Storage:** NREGS × XLEN registers and NREGS × PEND_W pending counters. Entry 0 has neither storage nor counter; reads of address 0 return 0 and busy 0.
- **Write:**
  - On a CLK edge with WR_EN=1 and WR_ADDR≠0, registers[WR_ADDR] ← WR_DATA.
  - WR_ADDR=0 is ignored.
  - WR_ADDR ≥ NREGS is ignored.
- **Read:** RSn = registers[ADDRn], combinational. If BYPASS=1 and WR_EN=1 and WR_ADDR=ADDRn≠0, then RSn = WR_DATA.
- **Issue handshake:**
  - ISSUE_RDY = (ISSUE_ADDR=0) OR (count[ISSUE_ADDR] < max) OR (WR_EN AND WR_ADDR=ISSUE_ADDR).
  - An issue is accepted when ISSUE_EN AND ISSUE_RDY; count[ISSUE_ADDR] then increments.
  - ISSUE_EN with ISSUE_RDY=0 has no effect; decode must stall and hold the request.
  - ISSUE_ADDR=0 is accepted and never counted.
- **Retire:**
  - WR_EN=1 with WR_ADDR≠0: count[WR_ADDR] decrements if nonzero.
  - If the count is 0, the data write still occurs, the count stays 0 and ERR_UNDERFLOW sets.
- **Simultaneous events:**
  - Accepted issue and retire on the same nonzero address: the count is unchanged and no underflow is flagged.
  - Issue and retire on different addresses: both take effect independently.
- **Busy:**
  - RSn_BUSY = count[ADDRn]≠0.
  - With BYPASS=1 this is suppressed when WR_EN AND WR_ADDR=ADDRn AND count[ADDRn]=1, because the last pending value is being forwarded this cycle.
  - With BYPASS=0 there is no suppression.
- **PEND_ANY:** OR of all counts ≠ 0, registered-state based, combinational output.
- **Reset:**
  - RST=1 at a CLK edge clears all registers, all counts and ERR_UNDERFLOW. This has priority over any concurrent write, issue or retire, including mid-flight pending writes.
  - After reset: RS1=RS2=0, busy=0, ISSUE_RDY=1, PEND_ANY=0, ERR_UNDERFLOW=0.

## Timing
- **Read latency:** 0 cycles (combinational from ADDRn, and from WR_* when BYPASS=1).
- **Write latency:** data written at edge k is readable from stored state after edge k. With BYPASS=1 it is also visible in cycle k itself.
- **Count updates:** take effect at the same edge as the accepting strobe. Busy reflects them in the following cycle.
- **Handshake outputs:** ISSUE_RDY and busy are combinational. There are no loops from ISSUE_EN to ISSUE_RDY.
- **ERR_UNDERFLOW:** rises the cycle after the offending edge and holds until RST.

## Test plan
- **Reset and zero register:**
  - Stimulus: write x5=0xDEADBEEF, then RST=1 for one cycle.
  - Required: RS1(x5)=0, busy=0, ISSUE_RDY=1. Write x0=0x1234, then read x0: returns 0 and RS1_BUSY=0.
- **Scoreboard and bypass:**
  - Stimulus: issue x7, then ADDR1=7.
  - Required: RS1_BUSY=1. In the retire cycle WR_EN=1, WR_ADDR=7, WR_DATA=0xA5A5A5A5: RS1=0xA5A5A5A5 and RS1_BUSY=0 in the same cycle, and the next cycle still reads 0xA5A5A5A5.
- **BYPASS=0 instance:**
  - Stimulus: same as the scoreboard-and-bypass scenario.
  - Required: in the retire cycle RS1 shows the old value and RS1_BUSY=1; the next cycle shows the new value and RS1_BUSY=0.
- **Counter saturation (PEND_W=2):**
  - Stimulus: issue x3 three times, then ISSUE_EN on x3 again.
  - Required: ISSUE_RDY=0 and the count stays 3. Repeating the fourth issue with a concurrent retire of x3 gives ISSUE_RDY=1 and the count stays 3. Three more retires give busy=0 and PEND_ANY=0.
- **Underflow:**
  - Stimulus: retire x9 with no prior issue, data 0x11.
  - Required: x9 reads 0x11, ERR_UNDERFLOW=1 from the next cycle, cleared by RST.
- **Reset mid-operation:**
  - Stimulus: issue x4 and x6, and assert RST in the same cycle as a retire of x4.
  - Required: all counts 0, x4 reads 0, PEND_ANY=0.
